serial_frame_receiver: RTL and testbench
========================================

# serial_frame_receiver

Downstream consumer of the serial bit stream produced by the parameterized shift register (its `shift_out`). Detects a start bit and assembles `DATA_WIDTH` data bits in the order implied by the upstream shift direction. Checks optional even parity and the stop bit. Presents each word on a valid/ready output with a one-deep holding register and a sticky overrun flag.

## Interface
- `DATA_WIDTH`, 8, data bits per frame (≥2).
- `SHIFT_DIRECTION`, "LEFT", upstream direction; "LEFT" means the MSB arrives first, "RIGHT" means the LSB arrives first.
- `PARITY_EN`, 1, 1 means one even-parity bit follows the data; 0 means no parity bit.
- `clock`  in  1  single clock; all logic is on the rising edge.
- `Sclr`  in  1  synchronous, active-high reset; highest priority.
- `enable`  in  1  bit strobe; `serial_in` is sampled only on edges where `enable`=1.
- `serial_in`  in  1  serial stream; idle level is 1.
- `ready`  in  1  downstream accepts the word on an edge where `valid`&&`ready`.
- `data`  out  DATA_WIDTH  received word.
- `valid`  out  1  `data` and the error flags hold a frame.
- `parity_err`  out  1  parity mismatch for the held frame; qualified by `valid`.
- `frame_err`  out  1  stop bit was 0 for the held frame; qualified by `valid`.
- `overrun`  out  1  sticky: a completed frame was dropped because the holding register was full.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- All outputs are registered. On reset: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0, state=IDLE, bit counter=0.
- FSM states are IDLE, DATA, PARITY, STOP. Transitions happen only on edges where `enable`=1; with `enable`=0 the state, counter and shift register hold.
- IDLE: a sample of `serial_in`=0 moves to DATA with count=0. A sample of 1 stays in IDLE. There is no start-bit re-validation.
- DATA: each sample is shifted into the assembly register.
  - LEFT: the new bit enters at bit 0 and earlier bits move toward the MSB, so the first bit received ends up as the MSB.
  - RIGHT: the new bit enters at the MSB and earlier bits move toward bit 0, so the first bit received ends up as bit 0.
  - After the `DATA_WIDTH`-th sample, move to PARITY if `PARITY_EN`=1, else to STOP.
- PARITY: `perr` = XOR-reduction of the assembled word XOR the sampled bit. A result of 1 is an error (even parity). Move to STOP.
- STOP: `ferr` = the inverse of the sampled bit. Complete the frame and return to IDLE.
- Completion:
  - If `valid`=0, or `valid`&&`ready` on the same edge, load `data`, `parity_err`=`perr`, `frame_err`=`ferr` and `valid`=1.
  - Otherwise set `overrun`=1 and discard the new frame; the held word is unchanged.
  - Frames with errors are still delivered, with their flags set.
- Handshake: `valid` stays high and `data` and the flags stay stable until `valid`&&`ready`. After the transfer, `valid` falls on the next edge unless a completion loads a new word on that same edge.
- `overrun` clears only on `Sclr`.
- `Sclr` mid-frame aborts the frame, discards the partial word and clears all outputs. The next start bit is searched from IDLE.

## Timing
- A frame occupies 2+`DATA_WIDTH`+`PARITY_EN` enabled samples.
- `busy` rises on the edge after the start-bit sample edge. It falls on the edge after the stop-bit sample.
- `valid` is high on the edge after the stop-bit sample edge, i.e. 1 clock of latency.
  - With `enable` held at 1 and the start sampled at edge 0, for W=8 with parity, the stop bit is sampled at edge 10 and `valid` is visible after edge 10.
- Throughput: back-to-back frames are supported. A new start bit may be sampled on the edge immediately after the stop bit.
- `ready` is used only at completion edges and for clearing `valid`. There is no combinational path from any input to any output.

## Structure
- Shared package `serial_rx_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3);
  - the even-parity function;
  - the frame-length constant expression.
- Sub-module `rx_shift_reg`: a direction-parameterized deserializing register with `enable`, `Sclr` and a serial input, and a parallel output.
- The FSM, bit counter, checks and holding register live in the top level.

## Test plan
All scenarios use W=8, LEFT, `PARITY_EN`=1 unless noted.
- Reset: `Sclr`=1 for 2 cycles with random inputs → every output is 0 and `busy`=0.
- Good frame: bits 0, 1,0,1,0,0,1,0,1 (0xA5 MSB first), parity 0, stop 1, `enable`=1, `ready`=1 → one-cycle `valid` with `data`=8'hA5 and both error flags 0. Repeat with `enable` toggling 1/0 → the same result at twice the latency.
- Errors: the 0xA5 frame with parity bit 1 → `parity_err`=1 and `data`=A5. The 0xA5 frame with stop bit 0 → `frame_err`=1, with `valid` still asserted.
- Backpressure: `ready`=0 with back-to-back frames 0x3C then 0xC3 → `data`=3C held, and `overrun`=1 after the second stop bit. Then `ready`=1 for one cycle → `valid`=0, and `overrun` stays 1.
- Abort: `Sclr` pulse after 4 data bits, then idle 1s → `busy`=0 and no `valid`. A following 0x0F frame is received correctly. Also run with RIGHT, `PARITY_EN`=0, and LSB-first bits of 0x81 → `data`=8'h81.

Source files
------------

// File: rtl/serial_frame_receiver_pkg.sv
// serial_rx_pkg: types and helpers shared by the serial frame receiver.
//   state_t          - receiver FSM encoding
//   even_parity_err  - 1 when word plus parity bit has odd weight
//   frame_len        - number of enabled samples one frame occupies
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which does not change the XOR reduction.
    localparam int PARITY_W = 64;

    function automatic logic even_parity_err(input logic [PARITY_W-1:0] word,
                                             input logic parity_bit);
        return (^word) ^ parity_bit;
    endfunction

    // Start bit + data bits + optional parity bit + stop bit.
    function automatic int frame_len(input int data_width, input int parity_en);
        return 2 + data_width + parity_en;
    endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// serial_frame_receiver_if: valid/ready word output of the frame receiver.
//   data        - received word
//   valid       - data and flags hold a frame
//   ready       - consumer accepts on valid && ready
//   parity_err  - parity mismatch of the held frame
//   frame_err   - stop bit was 0 for the held frame
// master: receiver side, slave: consumer side.
interface serial_frame_receiver_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  parity_err;
    logic                  frame_err;

    modport master (output data, valid, parity_err, frame_err, input ready);
    modport slave  (input data, valid, parity_err, frame_err, output ready);
endinterface

// File: rtl/serial_frame_receiver_rx_shift_reg.sv
// rx_shift_reg: deserializing register.
//   clock, Sclr (sync active-high), enable (shift strobe), serial_in, q (parallel word)
// LEFT : new bit enters at bit 0, first bit received ends up as the MSB.
// RIGHT: new bit enters at the MSB, first bit received ends up as bit 0.
module rx_shift_reg #(
    parameter int    DATA_WIDTH      = 8,
    parameter string SHIFT_DIRECTION = "LEFT"
) (
    input  logic                  clock,
    input  logic                  Sclr,
    input  logic                  enable,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] q
);
    generate
        if (SHIFT_DIRECTION == "LEFT") begin : g_left
            always_ff @(posedge clock) begin
                if (Sclr)        q <= '0;
                else if (enable) q <= {q[DATA_WIDTH-2:0], serial_in};
            end
        end else begin : g_right
            always_ff @(posedge clock) begin
                if (Sclr)        q <= '0;
                else if (enable) q <= {serial_in, q[DATA_WIDTH-1:1]};
            end
        end
    endgenerate
endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: start-bit detect, data assembly, even parity and stop
// bit checks, one-deep holding register with sticky overrun.
//   clock, Sclr      - clock and sync active-high reset
//   enable           - bit strobe; serial_in sampled only when high
//   serial_in        - serial stream, idle high
//   rx_bus (master)  - data/valid/ready/parity_err/frame_err
//   overrun          - sticky: completed frame dropped while holding reg full
//   busy             - FSM not in IDLE
module serial_frame_receiver
    import serial_rx_pkg::*;
#(
    parameter int    DATA_WIDTH      = 8,
    parameter string SHIFT_DIRECTION = "LEFT",
    parameter int    PARITY_EN       = 1
) (
    input  logic                    clock,
    input  logic                    Sclr,
    input  logic                    enable,
    input  logic                    serial_in,
    serial_frame_receiver_if.master rx_bus,
    output logic                    overrun,
    output logic                    busy
);
    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  perr;
    logic [DATA_WIDTH-1:0] word;

    // The assembly register only shifts on data-bit samples; it holds the
    // finished word through the parity and stop samples.
    rx_shift_reg #(
        .DATA_WIDTH      (DATA_WIDTH),
        .SHIFT_DIRECTION (SHIFT_DIRECTION)
    ) u_shift (
        .clock     (clock),
        .Sclr      (Sclr),
        .enable    (enable && (state == DATA)),
        .serial_in (serial_in),
        .q         (word)
    );

    always_ff @(posedge clock) begin
        if (Sclr) begin
            state             <= IDLE;
            bit_cnt           <= '0;
            perr              <= 1'b0;
            busy              <= 1'b0;
            overrun           <= 1'b0;
            rx_bus.data       <= '0;
            rx_bus.valid      <= 1'b0;
            rx_bus.parity_err <= 1'b0;
            rx_bus.frame_err  <= 1'b0;
        end else begin
            // A transfer drops valid; a completion below on this same edge
            // overrides it with the new word.
            if (rx_bus.valid && rx_bus.ready)
                rx_bus.valid <= 1'b0;

            if (enable) begin
                case (state)
                    IDLE: begin
                        if (!serial_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            perr    <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_CNT)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                    PARITY: begin
                        perr  <= even_parity_err(PARITY_W'(word), serial_in);
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!rx_bus.valid || rx_bus.ready) begin
                            rx_bus.data       <= word;
                            rx_bus.parity_err <= perr;
                            rx_bus.frame_err  <= ~serial_in;
                            rx_bus.valid      <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench: one LEFT/parity receiver and one RIGHT/no-parity receiver
// driven by the same stimulus.
module tb_serial_frame_receiver;
    logic clock = 1'b0;
    logic Sclr, enable, serial_in, ready;
    logic ov_l, busy_l, ov_r, busy_r;
    int   n_total = 0;
    int   n_pass  = 0;

    serial_frame_receiver_if #(.DATA_WIDTH(8)) bus_l ();
    serial_frame_receiver_if #(.DATA_WIDTH(8)) bus_r ();

    assign bus_l.ready = ready;
    assign bus_r.ready = ready;

    serial_frame_receiver #(.DATA_WIDTH(8), .SHIFT_DIRECTION("LEFT"), .PARITY_EN(1)) dut_l (
        .clock(clock), .Sclr(Sclr), .enable(enable), .serial_in(serial_in),
        .rx_bus(bus_l), .overrun(ov_l), .busy(busy_l)
    );

    serial_frame_receiver #(.DATA_WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .PARITY_EN(0)) dut_r (
        .clock(clock), .Sclr(Sclr), .enable(enable), .serial_in(serial_in),
        .rx_bus(bus_r), .overrun(ov_r), .busy(busy_r)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic edge1();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        enable    = 1'b1;
        repeat (n) edge1();
    endtask

    // One enabled sample; with tog set, a disabled edge precedes it.
    task automatic bit_in(input logic b, input logic tog);
        if (tog) begin
            enable = 1'b0;
            edge1();
        end
        serial_in = b;
        enable    = 1'b1;
        edge1();
    endtask

    // Ends just after the stop-bit sample edge.
    task automatic frame(input logic [7:0] w, input logic par, input logic stp,
                         input logic lsb_first, input logic use_par, input logic tog);
        bit_in(1'b0, tog);
        check("busy_after_start", {31'd0, busy_l}, 32'd1);
        for (int i = 0; i < 8; i++)
            bit_in(lsb_first ? w[i] : w[7-i], tog);
        if (use_par) bit_in(par, tog);
        bit_in(stp, tog);
    endtask

    initial begin
        // Reset with random inputs
        Sclr = 1'b1;
        repeat (2) begin
            serial_in = 1'($urandom);
            enable    = 1'($urandom);
            ready     = 1'($urandom);
            edge1();
        end
        check("rst_data",   {24'd0, bus_l.data}, 32'd0);
        check("rst_valid",  {31'd0, bus_l.valid}, 32'd0);
        check("rst_perr",   {31'd0, bus_l.parity_err}, 32'd0);
        check("rst_ferr",   {31'd0, bus_l.frame_err}, 32'd0);
        check("rst_ovr",    {31'd0, ov_l}, 32'd0);
        check("rst_busy",   {31'd0, busy_l}, 32'd0);
        check("rst_r_valid",{31'd0, bus_r.valid}, 32'd0);
        check("rst_r_busy", {31'd0, busy_r}, 32'd0);
        Sclr  = 1'b0;
        ready = 1'b1;
        idle(2);
        check("idle_busy", {31'd0, busy_l}, 32'd0);

        // Good frame 0xA5
        frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("good_valid", {31'd0, bus_l.valid}, 32'd1);
        check("good_data",  {24'd0, bus_l.data}, 32'hA5);
        check("good_perr",  {31'd0, bus_l.parity_err}, 32'd0);
        check("good_ferr",  {31'd0, bus_l.frame_err}, 32'd0);
        check("good_busy",  {31'd0, busy_l}, 32'd0);
        idle(1);
        check("good_valid_fall", {31'd0, bus_l.valid}, 32'd0);

        // Same frame with enable toggling
        frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("tog_valid", {31'd0, bus_l.valid}, 32'd1);
        check("tog_data",  {24'd0, bus_l.data}, 32'hA5);
        check("tog_perr",  {31'd0, bus_l.parity_err}, 32'd0);
        idle(1);

        // Parity error
        frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("perr_valid", {31'd0, bus_l.valid}, 32'd1);
        check("perr_flag",  {31'd0, bus_l.parity_err}, 32'd1);
        check("perr_data",  {24'd0, bus_l.data}, 32'hA5);
        check("perr_ferr",  {31'd0, bus_l.frame_err}, 32'd0);
        idle(1);

        // Framing error
        frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ferr_valid", {31'd0, bus_l.valid}, 32'd1);
        check("ferr_flag",  {31'd0, bus_l.frame_err}, 32'd1);
        check("ferr_perr",  {31'd0, bus_l.parity_err}, 32'd0);
        idle(1);

        // Backpressure: back-to-back 0x3C then 0xC3 with ready low
        ready = 1'b0;
        frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("bp_valid1", {31'd0, bus_l.valid}, 32'd1);
        check("bp_data1",  {24'd0, bus_l.data}, 32'h3C);
        check("bp_ovr1",   {31'd0, ov_l}, 32'd0);
        frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("bp_data2",  {24'd0, bus_l.data}, 32'h3C);
        check("bp_valid2", {31'd0, bus_l.valid}, 32'd1);
        check("bp_ovr2",   {31'd0, ov_l}, 32'd1);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        check("bp_valid_fall", {31'd0, bus_l.valid}, 32'd0);
        check("bp_ovr_sticky", {31'd0, ov_l}, 32'd1);
        idle(2);
        check("bp_ovr_sticky2", {31'd0, ov_l}, 32'd1);

        // Abort after 4 data bits
        ready = 1'b1;
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        check("abort_busy_pre", {31'd0, busy_l}, 32'd1);
        Sclr      = 1'b1;
        serial_in = 1'b1;
        edge1();
        Sclr = 1'b0;
        check("abort_busy",  {31'd0, busy_l}, 32'd0);
        check("abort_valid", {31'd0, bus_l.valid}, 32'd0);
        check("abort_ovr",   {31'd0, ov_l}, 32'd0);
        idle(4);
        check("abort_idle_busy",  {31'd0, busy_l}, 32'd0);
        check("abort_idle_valid", {31'd0, bus_l.valid}, 32'd0);
        frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("after_abort_valid", {31'd0, bus_l.valid}, 32'd1);
        check("after_abort_data",  {24'd0, bus_l.data}, 32'h0F);
        check("after_abort_perr",  {31'd0, bus_l.parity_err}, 32'd0);
        idle(1);

        // RIGHT, no parity, 0x81 LSB first
        Sclr = 1'b1;
        edge1();
        Sclr = 1'b0;
        idle(1);
        frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("right_valid", {31'd0, bus_r.valid}, 32'd1);
        check("right_data",  {24'd0, bus_r.data}, 32'h81);
        check("right_perr",  {31'd0, bus_r.parity_err}, 32'd0);
        check("right_ferr",  {31'd0, bus_r.frame_err}, 32'd0);
        check("right_busy",  {31'd0, busy_r}, 32'd0);
        idle(1);
        check("right_valid_fall", {31'd0, bus_r.valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
